// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the iterative multiply/divide unit.
//   - operation select values for mul_or_div_i
//   - operand signedness values for reg*_signed0_unsigned1_i
//   - FSM state encoding (2-bit)
package muldiv_pkg;

   localparam logic MUL      = 1'b0;
   localparam logic DIV      = 1'b1;

   localparam logic SIGNED   = 1'b0;
   localparam logic UNSIGNED = 1'b1;

   typedef enum logic [1:0] {
      MULDIV_IDLE = 2'd0,
      MULDIV_CALC = 2'd1,
      MULDIV_DONE = 2'd2
   } muldiv_state_e;

endpackage

// File: rtl/muldiv_negate.sv
// muldiv_negate: combinational conditional two's-complement.
// Used both to take operand magnitudes and to sign-fix results.
//   value  : input operand, W bits
//   neg    : 1 = return -value, 0 = pass value through
//   result : output, W bits
module muldiv_negate #(
   parameter int W = 32
) (
   input  logic [W-1:0] value,
   input  logic         neg,
   output logic [W-1:0] result
);

   assign result = neg ? ((~value) + W'(1)) : value;

endmodule

// File: rtl/muldiv.sv
// muldiv: iterative multiply/divide unit beside the execute stage.
// Multiply gives the 2*XLEN product {hi,lo}; divide gives {quotient,remainder}.
// Optional build macro: MULDIV_FAST_MUL_EN -- single-cycle multiply (IDLE->DONE).
// Ports:
//   clk                       system clock, rising edge
//   rst                       asynchronous reset, active low
//   start_i                   level request, held by execute until done_o
//   mul_or_div_i              0 multiply, 1 divide
//   dividend_i / divisor_i    rs1 / rs2 operands
//   reg1/reg2_signed0_unsigned1_i  operand signedness (0 signed, 1 unsigned)
//   cancel_i                  flush; aborts CALC, blocks acceptance in IDLE
//   result_o                  registered result, held until next DONE
//   done_o                    one-cycle strobe, result_o valid
//   busy_o                    high in CALC
//
// state | meaning
// IDLE  | waiting for start_i with cancel_i low; operands captured on accept
// CALC  | one shift-add / restoring-divide step per cycle, XLEN cycles
// DONE  | done_o strobe, result_o already registered
module muldiv
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              mul_or_div_i,
   input  logic [XLEN-1:0]   dividend_i,
   input  logic [XLEN-1:0]   divisor_i,
   input  logic              reg1_signed0_unsigned1_i,
   input  logic              reg2_signed0_unsigned1_i,
   input  logic              cancel_i,
   output logic [2*XLEN-1:0] result_o,
   output logic              done_o,
   output logic              busy_o
);

   localparam int              CNT_W    = $clog2(XLEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

   muldiv_state_e     state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              op_div_q;
   logic              neg_q_q;
   logic              neg_r_q;
   logic [XLEN-1:0]   opnd_q;
   logic [2*XLEN-1:0] acc_q;
   logic [2*XLEN-1:0] acc_next;
   logic [2*XLEN-1:0] result_q;

   logic              sa, sb;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic              accept;
   logic              div_by_zero;
   logic              fast_mul;
   logic              calc_abort;
   logic              calc_last;

   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_hi;
   logic [XLEN-1:0]   div_sub;

   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix;
   logic [2*XLEN-1:0] calc_result;

   assign sa = (reg1_signed0_unsigned1_i == SIGNED) && dividend_i[XLEN-1];
   assign sb = (reg2_signed0_unsigned1_i == SIGNED) && divisor_i[XLEN-1];

   // Most negative value maps to itself, which read unsigned is the correct magnitude.
   muldiv_negate #(.W(XLEN)) u_abs_a (.value(dividend_i), .neg(sa), .result(a_mag));
   muldiv_negate #(.W(XLEN)) u_abs_b (.value(divisor_i),  .neg(sb), .result(b_mag));

   assign accept      = start_i && !cancel_i;
   assign div_by_zero = (mul_or_div_i == DIV) && (divisor_i == '0);
   assign calc_abort  = cancel_i || !start_i;
   assign calc_last   = (cnt_q == CNT_LAST);

`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] a_ext, b_ext, fast_product;
   // Low 2*XLEN bits of the sign-extended product are exact for every signedness mix.
   assign a_ext        = {{XLEN{sa}}, dividend_i};
   assign b_ext        = {{XLEN{sb}}, divisor_i};
   assign fast_product = a_ext * b_ext;
   assign fast_mul     = (mul_or_div_i == MUL);
`else
   assign fast_mul     = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= MULDIV_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         MULDIV_IDLE: begin
            if (accept) begin
               if (div_by_zero || fast_mul) state_d = MULDIV_DONE;
               else                         state_d = MULDIV_CALC;
            end
         end
         MULDIV_CALC: begin
            if (calc_abort)     state_d = MULDIV_IDLE;
            else if (calc_last) state_d = MULDIV_DONE;
         end
         MULDIV_DONE: state_d = MULDIV_IDLE;
         default:     state_d = MULDIV_IDLE;
      endcase
   end

   // acc holds {hi,lo} for multiply and {remainder,dividend/quotient} for divide.
   always_comb begin
      acc_next = acc_q;
      mul_sum  = '0;
      div_hi   = '0;
      div_sub  = '0;
      if (op_div_q) begin
         div_hi  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
         div_sub = div_hi[XLEN-1:0] - opnd_q;
         if (div_hi >= {1'b0, opnd_q})
            acc_next = {div_sub, acc_q[XLEN-2:0], 1'b1};
         else
            acc_next = {div_hi[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end else begin
         mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
         acc_next = {mul_sum, acc_q[XLEN-1:1]};
      end
   end

   // Sign fix is applied to the final step's value so result_o is ready in DONE.
   muldiv_negate #(.W(2*XLEN)) u_fix_prod (.value(acc_next),                   .neg(neg_q_q), .result(prod_fix));
   muldiv_negate #(.W(XLEN))   u_fix_quo  (.value(acc_next[XLEN-1:0]),         .neg(neg_q_q), .result(quo_fix));
   muldiv_negate #(.W(XLEN))   u_fix_rem  (.value(acc_next[2*XLEN-1:XLEN]),    .neg(neg_r_q), .result(rem_fix));

   assign calc_result = op_div_q ? {quo_fix, rem_fix} : prod_fix;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q    <= '0;
         op_div_q <= 1'b0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         opnd_q   <= '0;
         acc_q    <= '0;
         result_q <= '0;
      end else begin
         case (state_q)
            MULDIV_IDLE: begin
               if (accept) begin
                  op_div_q <= mul_or_div_i;
                  neg_q_q  <= sa ^ sb;
                  neg_r_q  <= sa;
                  cnt_q    <= '0;
                  opnd_q   <= (mul_or_div_i == DIV) ? b_mag : a_mag;
                  acc_q    <= {{XLEN{1'b0}}, ((mul_or_div_i == DIV) ? a_mag : b_mag)};
                  if (div_by_zero)
                     result_q <= {{XLEN{1'b1}}, dividend_i};
`ifdef MULDIV_FAST_MUL_EN
                  else if (fast_mul)
                     result_q <= fast_product;
`endif
               end
            end
            MULDIV_CALC: begin
               if (calc_abort) begin
                  cnt_q <= '0;
               end else begin
                  acc_q <= acc_next;
                  cnt_q <= calc_last ? '0 : cnt_q + CNT_W'(1);
                  if (calc_last) result_q <= calc_result;
               end
            end
            default: ;
         endcase
      end
   end

   assign result_o = result_q;
   assign done_o   = (state_q == MULDIV_DONE);
   assign busy_o   = (state_q == MULDIV_CALC);

endmodule

// File: tb/tb_muldiv.sv
// tb_muldiv: directed self-checking bench for muldiv.
module tb_muldiv;

   localparam logic MUL = 1'b0;
   localparam logic DIV = 1'b1;
   localparam logic SGN = 1'b0;
   localparam logic UNS = 1'b1;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT  = 1;
   localparam int MUL_BUSY = 0;
`else
   localparam int MUL_LAT  = 33;
   localparam int MUL_BUSY = 32;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_i = 1'b0;
   logic        mul_or_div_i = 1'b0;
   logic [31:0] dividend_i = '0;
   logic [31:0] divisor_i = '0;
   logic        reg1_signed0_unsigned1_i = 1'b1;
   logic        reg2_signed0_unsigned1_i = 1'b1;
   logic        cancel_i = 1'b0;
   logic [63:0] result_o;
   logic        done_o;
   logic        busy_o;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   logic [63:0] prev_result = '0;

   muldiv #(.XLEN(32)) dut (
      .clk                      (clk),
      .rst                      (rst),
      .start_i                  (start_i),
      .mul_or_div_i             (mul_or_div_i),
      .dividend_i               (dividend_i),
      .divisor_i                (divisor_i),
      .reg1_signed0_unsigned1_i (reg1_signed0_unsigned1_i),
      .reg2_signed0_unsigned1_i (reg2_signed0_unsigned1_i),
      .cancel_i                 (cancel_i),
      .result_o                 (result_o),
      .done_o                   (done_o),
      .busy_o                   (busy_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drives one operation like execute does; lat = -1 if done_o never arrives.
   task automatic do_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic s1, input logic s2, input bit scramble,
                        output int lat, output int busy_n, output logic [63:0] res,
                        output int t_start);
      @(negedge clk);
      mul_or_div_i = op;
      dividend_i = a;
      divisor_i = b;
      reg1_signed0_unsigned1_i = s1;
      reg2_signed0_unsigned1_i = s2;
      start_i = 1'b1;
      @(posedge clk);
      lat = -1;
      busy_n = 0;
      res = '0;
      t_start = 0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (k == 1) t_start = cyc;
         if (scramble) begin
            dividend_i = $urandom;
            divisor_i = $urandom;
         end
         if (busy_o) busy_n++;
         if (done_o) begin
            lat = k;
            res = result_o;
            start_i = 1'b0;
            break;
         end
      end
      start_i = 1'b0;
      @(posedge clk);
   endtask

   task automatic test_reset;
      start_i = 1'b1;
      mul_or_div_i = DIV;
      dividend_i = 32'd100;
      divisor_i = 32'd7;
      repeat (3) @(negedge clk);
      n_checks++;
      if (result_o !== 64'd0 || done_o !== 1'b0 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got result=%h done=%b busy=%b expected 0/0/0", result_o, done_o, busy_o);
      end
      start_i = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release_idle: got done=%b busy=%b expected 0/0", done_o, busy_o);
      end
   endtask

   task automatic test_divu;
      int lat, busy_n, t0;
      logic [63:0] res;
      do_op(DIV, 32'd100, 32'd7, UNS, UNS, 1'b0, lat, busy_n, res, t0);
      n_checks++;
      if (lat !== 33) begin n_fail++; $display("FAIL divu_latency: got %0d expected 33", lat); end
      n_checks++;
      if (busy_n !== 32) begin n_fail++; $display("FAIL divu_busy_cycles: got %0d expected 32", busy_n); end
      n_checks++;
      if (res !== {32'd14, 32'd2}) begin n_fail++; $display("FAIL divu_result: got %h expected %h", res, {32'd14, 32'd2}); end
      prev_result = {32'd14, 32'd2};
   endtask

   task automatic test_div_signed;
      int lat, busy_n, t0;
      logic [63:0] res;
      do_op(DIV, 32'hFFFFFFF9, 32'd2, SGN, SGN, 1'b1, lat, busy_n, res, t0);
      n_checks++;
      if (res !== 64'hFFFFFFFD_FFFFFFFF) begin n_fail++; $display("FAIL div_neg7_by_2: got %h expected %h", res, 64'hFFFFFFFD_FFFFFFFF); end
      do_op(DIV, 32'h80000000, 32'hFFFFFFFF, SGN, SGN, 1'b0, lat, busy_n, res, t0);
      n_checks++;
      if (res !== 64'h80000000_00000000) begin n_fail++; $display("FAIL div_overflow: got %h expected %h", res, 64'h80000000_00000000); end
      n_checks++;
      if (lat !== 33) begin n_fail++; $display("FAIL div_overflow_latency: got %0d expected 33", lat); end
      prev_result = 64'h80000000_00000000;
   endtask

   task automatic test_div_by_zero;
      int lat, busy_n, t0;
      logic [63:0] res;
      do_op(DIV, 32'h1234, 32'd0, SGN, SGN, 1'b0, lat, busy_n, res, t0);
      n_checks++;
      if (lat !== 1) begin n_fail++; $display("FAIL div0_signed_latency: got %0d expected 1", lat); end
      n_checks++;
      if (res !== 64'hFFFFFFFF_00001234) begin n_fail++; $display("FAIL div0_signed_result: got %h expected %h", res, 64'hFFFFFFFF_00001234); end
      n_checks++;
      if (busy_n !== 0) begin n_fail++; $display("FAIL div0_busy_cycles: got %0d expected 0", busy_n); end
      do_op(DIV, 32'h1234, 32'd0, UNS, UNS, 1'b0, lat, busy_n, res, t0);
      n_checks++;
      if (lat !== 1) begin n_fail++; $display("FAIL div0_unsigned_latency: got %0d expected 1", lat); end
      n_checks++;
      if (res !== 64'hFFFFFFFF_00001234) begin n_fail++; $display("FAIL div0_unsigned_result: got %h expected %h", res, 64'hFFFFFFFF_00001234); end
      prev_result = 64'hFFFFFFFF_00001234;
   endtask

   task automatic test_mul;
      int lat, busy_n, t0;
      logic [63:0] res;
      do_op(MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, SGN, SGN, 1'b0, lat, busy_n, res, t0);
      n_checks++;
      if (res !== 64'h1) begin n_fail++; $display("FAIL mul_ss: got %h expected %h", res, 64'h1); end
      n_checks++;
      if (lat !== MUL_LAT) begin n_fail++; $display("FAIL mul_latency: got %0d expected %0d", lat, MUL_LAT); end
      n_checks++;
      if (busy_n !== MUL_BUSY) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d expected %0d", busy_n, MUL_BUSY); end
      do_op(MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, UNS, UNS, 1'b0, lat, busy_n, res, t0);
      n_checks++;
      if (res !== 64'hFFFFFFFE_00000001) begin n_fail++; $display("FAIL mul_uu: got %h expected %h", res, 64'hFFFFFFFE_00000001); end
      do_op(MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, SGN, UNS, 1'b0, lat, busy_n, res, t0);
      n_checks++;
      if (res !== 64'hFFFFFFFF_00000001) begin n_fail++; $display("FAIL mul_su: got %h expected %h", res, 64'hFFFFFFFF_00000001); end
      do_op(MUL, 32'hFFFFFFF9, 32'd6, SGN, SGN, 1'b0, lat, busy_n, res, t0);
      n_checks++;
      if (res !== 64'hFFFFFFFF_FFFFFFD6) begin n_fail++; $display("FAIL mul_neg7_x6: got %h expected %h", res, 64'hFFFFFFFF_FFFFFFD6); end
      prev_result = 64'hFFFFFFFF_FFFFFFD6;
   endtask

   // abort_kind: 0 = cancel_i, 1 = start_i dropped
   task automatic test_abort(input int abort_kind);
      bit seen_done;
      @(negedge clk);
      mul_or_div_i = DIV;
      dividend_i = 32'd200;
      divisor_i = 32'd9;
      reg1_signed0_unsigned1_i = UNS;
      reg2_signed0_unsigned1_i = UNS;
      start_i = 1'b1;
      @(posedge clk);
      repeat (10) @(negedge clk);
      n_checks++;
      if (busy_o !== 1'b1) begin n_fail++; $display("FAIL abort%0d_busy_before: got %b expected 1", abort_kind, busy_o); end
      if (abort_kind == 0) cancel_i = 1'b1;
      else                 start_i = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0) begin
         n_fail++;
         $display("FAIL abort%0d_after: got busy=%b done=%b expected 0/0", abort_kind, busy_o, done_o);
      end
      cancel_i = 1'b0;
      start_i = 1'b0;
      seen_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done_o) seen_done = 1'b1;
      end
      n_checks++;
      if (seen_done !== 1'b0) begin n_fail++; $display("FAIL abort%0d_no_done: got done seen=%b expected 0", abort_kind, seen_done); end
      n_checks++;
      if (result_o !== prev_result) begin n_fail++; $display("FAIL abort%0d_result_held: got %h expected %h", abort_kind, result_o, prev_result); end
   endtask

   task automatic test_cancel_idle;
      bit seen;
      @(negedge clk);
      mul_or_div_i = DIV;
      dividend_i = 32'd50;
      divisor_i = 32'd0;
      start_i = 1'b1;
      cancel_i = 1'b1;
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (busy_o || done_o) seen = 1'b1;
      end
      start_i = 1'b0;
      cancel_i = 1'b0;
      n_checks++;
      if (seen !== 1'b0) begin n_fail++; $display("FAIL cancel_idle_blocks: got activity=%b expected 0", seen); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      mul_or_div_i = DIV;
      dividend_i = 32'd1000;
      divisor_i = 32'd3;
      start_i = 1'b1;
      @(posedge clk);
      repeat (10) @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if (result_o !== 64'd0 || done_o !== 1'b0 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_calc: got result=%h done=%b busy=%b expected 0/0/0", result_o, done_o, busy_o);
      end
      start_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      prev_result = 64'd0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int lat1, lat2, b1, b2, t1, t2;
      logic [63:0] r1, r2;
      do_op(DIV, 32'd100, 32'd7, UNS, UNS, 1'b0, lat1, b1, r1, t1);
      do_op(MUL, 32'd3, 32'd5, UNS, UNS, 1'b0, lat2, b2, r2, t2);
      n_checks++;
      if (r1 !== {32'd14, 32'd2}) begin n_fail++; $display("FAIL b2b_first_result: got %h expected %h", r1, {32'd14, 32'd2}); end
      n_checks++;
      if (t2 - t1 !== 34) begin n_fail++; $display("FAIL b2b_restart_edge: got T+%0d expected T+34", t2 - t1); end
      n_checks++;
      if ((t2 + lat2) - t1 !== 34 + MUL_LAT) begin
         n_fail++;
         $display("FAIL b2b_second_done: got T+%0d expected T+%0d", (t2 + lat2) - t1, 34 + MUL_LAT);
      end
      n_checks++;
      if (r2 !== 64'd15) begin n_fail++; $display("FAIL b2b_second_result: got %h expected %h", r2, 64'd15); end
   endtask

   initial begin
      test_reset();
      test_divu();
      test_div_signed();
      test_div_by_zero();
      test_mul();
      test_abort(0);
      test_abort(1);
      test_cancel_idle();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv.md
Name: muldiv

Overview:
- Iterative multiply/divide unit sitting beside the execute stage.
- Consumes the execute stage's start, operand and signedness outputs; returns a 64-bit result and a done strobe.
- Execute holds start_i high (operands stable) while its aluop is MUL*/DIV*/REM* and done_o is low; the pipeline controller stalls meanwhile.
- Multiply result is the 64-bit product {hi,lo}; divide result is {quotient,remainder}.

Parameters:
- XLEN, 32, operand width; result is 2*XLEN; iteration counter is clog2(XLEN) bits.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- start_i  input  1  operation request, level, held by execute until done_o
- mul_or_div_i  input  1  `MUL (0) multiply, `DIV (1) divide
- dividend_i  input  XLEN  multiplicand / dividend (rs1)
- divisor_i  input  XLEN  multiplier / divisor (rs2)
- reg1_signed0_unsigned1_i  input  1  rs1 signedness, `Signed=0 / `Unsigned=1
- reg2_signed0_unsigned1_i  input  1  rs2 signedness
- cancel_i  input  1  flush (interrupt/branch), aborts the operation
- result_o  output  2*XLEN  product {hi,lo} or {quotient,remainder}
- done_o  output  1  one-cycle strobe: result_o valid
- busy_o  output  1  high in CALC state

Behaviour:
- Reset (rst=0, async): state IDLE; result_o=0, done_o=0, busy_o=0, counter=0.
- States:
  - IDLE: start_i=1 and cancel_i=0 at edge T → capture operands, signedness, op; take magnitudes (abs only if signed and bit31 set; -2^31 maps to 2^31); record neg_q = sa^sb and neg_r = sa.
    - If divide and divisor==0 → DONE.
    - Otherwise → CALC with counter=0.
  - CALC: one iteration per cycle for XLEN cycles; counter wraps XLEN-1 → 0 and goes to DONE.
    - Multiply: shift-add on magnitudes, 2*XLEN accumulator.
    - Divide: restoring radix-2; shift remainder:dividend left one bit, trial-subtract divisor magnitude, set quotient bit if no borrow.
  - DONE: done_o=1 for exactly one cycle; result_o is sign-fixed and registered. Next state IDLE.
- Sign fix:
  - Product negated (two's complement, 64-bit) if neg_q.
  - Quotient negated if neg_q; remainder negated if neg_r.
- Divide by zero: quotient=all ones, remainder=dividend_i, for both signed and unsigned.
- Overflow (-2^31 / -1): the natural flow yields quotient 0x80000000, remainder 0. No special path.
- Latency from start sampled at edge T:
  - Normal: done_o high in cycle T+XLEN+1 (T+33).
  - Divide by zero: T+1.
- Execute drops start_i combinationally while done_o is high. The module returns to IDLE, so start_i seen again at T+34 begins a new operation.
- Operand changes during CALC are ignored; operands are latched at start.
- Abort: cancel_i=1, or start_i=0 while in CALC → IDLE at the next edge; done_o stays 0 and result_o is unchanged. cancel_i in IDLE blocks acceptance.
- cancel_i and the DONE cycle coinciding: done_o still pulses (result is already final); the consumer discards it.
- result_o holds its value after DONE until the next DONE.
- busy_o=1 exactly in CALC.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: multiply uses a single-cycle `*` on the 33-bit sign-extended operands, IDLE → DONE directly, done_o at T+1. Divide is unchanged.
- Undefined: multiply is iterative, 33-cycle latency as above.

Decomposition:
- yadan_defs.v holds `MUL/`DIV, `Signed/`Unsigned, `DoubleRegBus, and the state encodings MULDIV_IDLE/CALC/DONE (2-bit).
- One natural sub-module: muldiv_negate. It is combinational: conditional two's-complement for abs/fixup, parameterised width, instantiated for operands and results.

Test Plan:
- DIVU 100/7 (unsigned,unsigned) → done_o at T+33, result_o={32'd14,32'd2}, busy_o high for 32 cycles.
- DIV 0xFFFFFFF9 / 2 signed → {0xFFFFFFFD, 0xFFFFFFFF}. DIV 0x80000000 / 0xFFFFFFFF → {0x80000000, 0x00000000}.
- DIV and DIVU 0x1234 / 0 → done_o at T+1, {0xFFFFFFFF, 0x00001234}.
- Multiply 0xFFFFFFFF×0xFFFFFFFF:
  - signed/signed → 64'h1
  - unsigned/unsigned → 64'hFFFFFFFE_00000001
  - signed/unsigned → 64'hFFFFFFFF_00000001
  - Latency T+33, or T+1 with MULDIV_FAST_MUL_EN.
- Abort cases:
  - cancel_i at CALC cycle 10 → busy_o low next cycle, no done_o, result_o unchanged.
  - start_i dropped mid-CALC → same.
  - rst asserted mid-CALC → all outputs 0 immediately.
- Back-to-back DIVU 100/7 then MULHU 3×5 (start_i re-asserted at T+34) → second done_o at T+67, result_o=64'd15.
